// File: rtl/beep_arbiter.sv
// Fixed-priority arbiter sharing one PWM buzzer tone generator between alarm,
// key-click and music requesters, with preemption and a silent articulation gap.
module beep_arbiter #(
  parameter logic [15:0] TICK_MAX  = 16'd49_999,
  parameter logic [7:0]  GAP_TICKS = 8'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  input  logic [47:0] req_period,
  input  logic [23:0] req_dur,
  input  logic        mute,
  output logic [2:0]  req_ready,
  output logic [2:0]  done,
  output logic [2:0]  abort,
  output logic [2:0]  grant,
  output logic [15:0] tone_period,
  output logic        tone_en,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] tick_r, tick_s;
  logic [7:0]  dur_cnt_r, dur_cnt_s;
  logic [7:0]  gap_cnt_r, gap_cnt_s;
  logic [15:0] period_r, period_s;
  logic [7:0]  dur_r, dur_s;
  logic [2:0]  grant_r, grant_s;
  logic [2:0]  ready_r, ready_s;
  logic [2:0]  done_r, done_s;
  logic [2:0]  abort_r, abort_s;
  logic [15:0] tone_period_r, tone_period_s;
  logic        tone_en_r, tone_en_s;
  logic        busy_r, busy_s;

  logic [2:0]  cand_s, masked_s, pick_s;
  logic        accept_s, tick_wrap_s, finish_s;
  logic [15:0] sel_period_s;
  logic [7:0]  sel_dur_s;

  assign tick_wrap_s = (tick_r == TICK_MAX);
  assign finish_s    = (state_r == PLAY) &&
                       ((dur_r == 8'd0) || (tick_wrap_s && (dur_cnt_r == dur_r - 8'd1)));

  // Candidate ports: all in IDLE, only strictly higher priority than the owner in PLAY.
  always_comb begin
    cand_s = 3'b000;
    case (state_r)
      IDLE:    cand_s = 3'b111;
      PLAY:    cand_s = grant_r - 3'd1;
      default: cand_s = 3'b000;
    endcase
    masked_s = req_valid & cand_s;
    pick_s   = masked_s & (~masked_s + 3'd1);
    accept_s = |masked_s;
    case (pick_s)
      3'b001:  begin sel_period_s = req_period[15:0];  sel_dur_s = req_dur[7:0];   end
      3'b010:  begin sel_period_s = req_period[31:16]; sel_dur_s = req_dur[15:8];  end
      3'b100:  begin sel_period_s = req_period[47:32]; sel_dur_s = req_dur[23:16]; end
      default: begin sel_period_s = 16'd0;             sel_dur_s = 8'd0;           end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s       = state_r;
    tick_s        = tick_r;
    dur_cnt_s     = dur_cnt_r;
    gap_cnt_s     = gap_cnt_r;
    period_s      = period_r;
    dur_s         = dur_r;
    grant_s       = grant_r;
    ready_s       = 3'b000;
    done_s        = 3'b000;
    abort_s       = 3'b000;
    tone_period_s = 16'd0;
    tone_en_s     = 1'b0;

    case (state_r)
      IDLE: begin
        grant_s = 3'b000;
      end
      PLAY: begin
        tick_s    = tick_wrap_s ? 16'd0 : tick_r + 16'd1;
        dur_cnt_s = tick_wrap_s ? dur_cnt_r + 8'd1 : dur_cnt_r;
        if (finish_s) begin
          done_s    = grant_r;
          grant_s   = 3'b000;
          tick_s    = 16'd0;
          gap_cnt_s = 8'd0;
          state_s   = (GAP_TICKS == 8'd0) ? IDLE : GAP;
        end else begin
          tone_period_s = period_r;
          tone_en_s     = (period_r != 16'd0) && !mute;
        end
      end
      GAP: begin
        grant_s   = 3'b000;
        tick_s    = tick_wrap_s ? 16'd0 : tick_r + 16'd1;
        gap_cnt_s = tick_wrap_s ? gap_cnt_r + 8'd1 : gap_cnt_r;
        if (tick_wrap_s && (gap_cnt_r == GAP_TICKS - 8'd1)) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = 3'b000;
      end
    endcase

    // A completing owner reports done rather than abort when handing over.
    if (accept_s) begin
      if ((state_r == PLAY) && !finish_s) begin
        abort_s = grant_r;
      end else begin
        abort_s = 3'b000;
      end
      ready_s       = pick_s;
      grant_s       = pick_s;
      period_s      = sel_period_s;
      dur_s         = sel_dur_s;
      tick_s        = 16'd0;
      dur_cnt_s     = 8'd0;
      state_s       = PLAY;
      tone_period_s = sel_period_s;
      tone_en_s     = (sel_period_s != 16'd0) && (sel_dur_s != 8'd0) && !mute;
    end else begin
      ready_s = 3'b000;
    end

    busy_s = (state_s != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      tick_r        <= 16'd0;
      dur_cnt_r     <= 8'd0;
      gap_cnt_r     <= 8'd0;
      period_r      <= 16'd0;
      dur_r         <= 8'd0;
      grant_r       <= 3'b000;
      ready_r       <= 3'b000;
      done_r        <= 3'b000;
      abort_r       <= 3'b000;
      tone_period_r <= 16'd0;
      tone_en_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      tick_r        <= tick_s;
      dur_cnt_r     <= dur_cnt_s;
      gap_cnt_r     <= gap_cnt_s;
      period_r      <= period_s;
      dur_r         <= dur_s;
      grant_r       <= grant_s;
      ready_r       <= ready_s;
      done_r        <= done_s;
      abort_r       <= abort_s;
      tone_period_r <= tone_period_s;
      tone_en_r     <= tone_en_s;
      busy_r        <= busy_s;
    end
  end

  assign req_ready   = ready_r;
  assign done        = done_r;
  assign abort       = abort_r;
  assign grant       = grant_r;
  assign tone_period = tone_period_r;
  assign tone_en     = tone_en_r;
  assign busy        = busy_r;

endmodule
